// File: rtl/dqbpijx_seq.sv
// dqbpijx_seq: backward pass over a serial chain, link NUM_LINKS down to 1.
// Each link adds its child's accumulated force and emits the joint-axis (AZ)
// component as dtau/dq. It then pushes the total force to its parent through
// the transposed Rz(q)+translation spatial transform.
module dqbpijx_seq #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16,
  parameter int unsigned NUM_LINKS    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       link_in,
  input  logic [WIDTH-1:0] sinq_val_in,
  input  logic [WIDTH-1:0] cosq_val_in,
  input  logic [WIDTH-1:0] r_x_in,
  input  logic [WIDTH-1:0] r_y_in,
  input  logic [WIDTH-1:0] r_z_in,
  input  logic [WIDTH-1:0] dfdq_vec_in_AX,
  input  logic [WIDTH-1:0] dfdq_vec_in_AY,
  input  logic [WIDTH-1:0] dfdq_vec_in_AZ,
  input  logic [WIDTH-1:0] dfdq_vec_in_LX,
  input  logic [WIDTH-1:0] dfdq_vec_in_LY,
  input  logic [WIDTH-1:0] dfdq_vec_in_LZ,
  output logic             dtau_valid_out,
  output logic [WIDTH-1:0] dtau_out,
  output logic [2:0]       link_out,
  output logic             done_out,
  output logic             err_out
);

  localparam int unsigned LINK_W = 3;
  localparam int unsigned VEC_W  = 3;
  localparam int unsigned VEC_N  = 6;
  localparam int unsigned PROD_W = 2 * WIDTH;

  // Vector element order: 0..2 angular (AX,AY,AZ), 3..5 linear (LX,LY,LZ).
  localparam int unsigned AX = 0;
  localparam int unsigned AY = 1;
  localparam int unsigned AZ = 2;
  localparam int unsigned LX = 3;
  localparam int unsigned LY = 4;
  localparam int unsigned LZ = 5;

  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

  state_t state;

  logic [LINK_W-1:0] expected;
  logic [LINK_W-1:0] link_r;
  logic [WIDTH-1:0]  sin_r, cos_r, rx_r, ry_r, rz_r;
  logic [WIDTH-1:0]  din_r [VEC_N];
  logic [WIDTH-1:0]  t_r   [VEC_N];
  logic [WIDTH-1:0]  g_r   [3];
  logic [WIDTH-1:0]  m_r   [3];
  logic [WIDTH-1:0]  acc   [NUM_LINKS+1][VEC_N];

  logic [WIDTH-1:0]  din_c [VEC_N];
  logic [WIDTH-1:0]  p_c   [VEC_N];
  logic [LINK_W-1:0] exp_now_c;
  logic              accept_c;
  logic              order_ok_c;
  logic              load_c;

  // Fixed-point multiply: full signed product, arithmetic shift, low WIDTH bits kept.
  function automatic logic [WIDTH-1:0] fx_mul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [PROD_W-1:0] prod;
    prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    return WIDTH'(prod >>> DECIMAL_BITS);
  endfunction

  // Gather the local df/dq input into vector order.
  always_comb begin
    din_c[AX] = dfdq_vec_in_AX;
    din_c[AY] = dfdq_vec_in_AY;
    din_c[AZ] = dfdq_vec_in_AZ;
    din_c[LX] = dfdq_vec_in_LX;
    din_c[LY] = dfdq_vec_in_LY;
    din_c[LZ] = dfdq_vec_in_LZ;
  end

  // Link expected at accept; in S3 it already reflects the link completing on this edge.
  always_comb begin
    exp_now_c = expected;
    if (state == S3) begin
      exp_now_c = (link_r == LINK_W'(1)) ? LINK_W'(NUM_LINKS) : link_r - LINK_W'(1);
    end
  end

  assign accept_c   = valid_in & ready_out;
  assign order_ok_c = (link_in == exp_now_c);
  assign load_c     = accept_c & order_ok_c;

  // Force sent to the parent: p_lin = g, p_ang = m + r x g.
  always_comb begin
    p_c[AX] = m_r[0] + fx_mul(ry_r, g_r[2]) - fx_mul(rz_r, g_r[1]);
    p_c[AY] = m_r[1] + fx_mul(rz_r, g_r[0]) - fx_mul(rx_r, g_r[2]);
    p_c[AZ] = m_r[2] + fx_mul(rx_r, g_r[1]) - fx_mul(ry_r, g_r[0]);
    p_c[LX] = g_r[0];
    p_c[LY] = g_r[1];
    p_c[LZ] = g_r[2];
  end

  // Capture an in-order transaction; out-of-order ones leave these untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_r <= '0;
      sin_r  <= '0;
      cos_r  <= '0;
      rx_r   <= '0;
      ry_r   <= '0;
      rz_r   <= '0;
      for (int unsigned j = 0; j < VEC_N; j++) begin
        din_r[VEC_W'(j)] <= '0;
      end
    end else if (load_c) begin
      link_r <= link_in;
      sin_r  <= sinq_val_in;
      cos_r  <= cosq_val_in;
      rx_r   <= r_x_in;
      ry_r   <= r_y_in;
      rz_r   <= r_z_in;
      for (int unsigned j = 0; j < VEC_N; j++) begin
        din_r[VEC_W'(j)] <= din_c[VEC_W'(j)];
      end
    end
  end

  // Pipeline FSM: S1 accumulate, S2 rotate, S3 emit dtau and propagate to parent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ready_out      <= 1'b1;
      dtau_valid_out <= 1'b0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
      dtau_out       <= '0;
      link_out       <= '0;
      expected       <= LINK_W'(NUM_LINKS);
      for (int unsigned j = 0; j < VEC_N; j++) begin
        t_r[VEC_W'(j)] <= '0;
      end
      for (int unsigned k = 0; k < 3; k++) begin
        g_r[2'(k)] <= '0;
        m_r[2'(k)] <= '0;
      end
      for (int unsigned i = 0; i <= NUM_LINKS; i++) begin
        for (int unsigned j = 0; j < VEC_N; j++) begin
          acc[LINK_W'(i)][VEC_W'(j)] <= '0;
        end
      end
    end else begin
      dtau_valid_out <= 1'b0;
      done_out       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            if (order_ok_c) begin
              state     <= S1;
              ready_out <= 1'b0;
            end else begin
              err_out <= 1'b1;
            end
          end
        end
        S1: begin
          for (int unsigned j = 0; j < VEC_N; j++) begin
            t_r[VEC_W'(j)] <= din_r[VEC_W'(j)] + acc[link_r][VEC_W'(j)];
          end
          state <= S2;
        end
        S2: begin
          g_r[0]    <= fx_mul(cos_r, t_r[LX]) - fx_mul(sin_r, t_r[LY]);
          g_r[1]    <= fx_mul(sin_r, t_r[LX]) + fx_mul(cos_r, t_r[LY]);
          g_r[2]    <= t_r[LZ];
          m_r[0]    <= fx_mul(cos_r, t_r[AX]) - fx_mul(sin_r, t_r[AY]);
          m_r[1]    <= fx_mul(sin_r, t_r[AX]) + fx_mul(cos_r, t_r[AY]);
          m_r[2]    <= t_r[AZ];
          state     <= S3;
          ready_out <= 1'b1;
        end
        S3: begin
          dtau_out       <= t_r[AZ];
          link_out       <= link_r;
          dtau_valid_out <= 1'b1;
          if (link_r == LINK_W'(1)) begin
            // Chain complete: wipe all accumulators for the next pass.
            done_out <= 1'b1;
            expected <= LINK_W'(NUM_LINKS);
            for (int unsigned i = 0; i <= NUM_LINKS; i++) begin
              for (int unsigned j = 0; j < VEC_N; j++) begin
                acc[LINK_W'(i)][VEC_W'(j)] <= '0;
              end
            end
          end else begin
            expected <= link_r - LINK_W'(1);
            for (int unsigned j = 0; j < VEC_N; j++) begin
              acc[link_r - LINK_W'(1)][VEC_W'(j)] <=
                acc[link_r - LINK_W'(1)][VEC_W'(j)] + p_c[VEC_W'(j)];
            end
          end
          if (load_c) begin
            state     <= S1;
            ready_out <= 1'b0;
          end else begin
            if (accept_c) begin
              err_out <= 1'b1;
            end
            state     <= IDLE;
            ready_out <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dqbpijx_seq.sv
// Directed bench for dqbpijx_seq: identity chain, rotation, cross product,
// signed fixed-point, order error, backpressure and mid-run reset.
module tb_dqbpijx_seq;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  link_in;
  logic [31:0] sinq_val_in, cosq_val_in;
  logic [31:0] r_x_in, r_y_in, r_z_in;
  logic [31:0] d_ax, d_ay, d_az, d_lx, d_ly, d_lz;
  logic        dtau_valid_out;
  logic [31:0] dtau_out;
  logic [2:0]  link_out;
  logic        done_out;
  logic        err_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [2:0]  q_link [$];
  logic [31:0] q_dtau [$];
  logic        q_done [$];
  int          q_cyc  [$];

  dqbpijx_seq dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .link_in        (link_in),
    .sinq_val_in    (sinq_val_in),
    .cosq_val_in    (cosq_val_in),
    .r_x_in         (r_x_in),
    .r_y_in         (r_y_in),
    .r_z_in         (r_z_in),
    .dfdq_vec_in_AX (d_ax),
    .dfdq_vec_in_AY (d_ay),
    .dfdq_vec_in_AZ (d_az),
    .dfdq_vec_in_LX (d_lx),
    .dfdq_vec_in_LY (d_ly),
    .dfdq_vec_in_LZ (d_lz),
    .dtau_valid_out (dtau_valid_out),
    .dtau_out       (dtau_out),
    .link_out       (link_out),
    .done_out       (done_out),
    .err_out        (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp dtau pulses.
  always @(posedge clk) cyc++;

  // Record every dtau pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && dtau_valid_out) begin
      q_link.push_back(link_out);
      q_dtau.push_back(dtau_out);
      q_done.push_back(done_out);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_link.delete();
    q_dtau.delete();
    q_done.delete();
    q_cyc.delete();
  endtask

  task automatic set_in(input logic [2:0] l, input logic [31:0] s, input logic [31:0] c,
                        input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz,
                        input logic [31:0] ax, input logic [31:0] ay, input logic [31:0] az,
                        input logic [31:0] lx, input logic [31:0] ly, input logic [31:0] lz);
    link_in = l;
    sinq_val_in = s;
    cosq_val_in = c;
    r_x_in = rx;
    r_y_in = ry;
    r_z_in = rz;
    d_ax = ax;
    d_ay = ay;
    d_az = az;
    d_lx = lx;
    d_ly = ly;
    d_lz = lz;
  endtask

  // Hold valid_in until an edge with ready_out high has passed (bounded).
  task automatic send();
    bit r;
    int n;
    valid_in = 1'b1;
    n = 0;
    do begin
      r = ready_out;
      tick();
      n++;
    end while (!r && n < 20);
    chk("accept_wait", 32'(r), 32'd1);
  endtask

  task automatic wait_pulses(input int n);
    int k;
    k = 0;
    while (q_link.size() < n && k < 60) begin
      tick();
      k++;
    end
    chk("pulse_count", 32'(q_link.size()), 32'(n));
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_q();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready_out), 32'd1);
    chk({tag, "_valid"}, 32'(dtau_valid_out), 32'd0);
    chk({tag, "_done"},  32'(done_out), 32'd0);
    chk({tag, "_err"},   32'(err_out), 32'd0);
    chk({tag, "_dtau"},  dtau_out, 32'd0);
    chk({tag, "_link"},  32'(link_out), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    valid_in = 1'b0;
    set_in(3'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Identity chain: dtau = 1.0 .. 7.0 for links 7..1, 3 cycles apart.
    clear_q();
    for (int k = 7; k >= 1; k--) begin
      set_in(3'(k), '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
      send();
    end
    valid_in = 1'b0;
    wait_pulses(7);
    for (int i = 0; i < 7 && i < q_link.size(); i++) begin
      logic [31:0] e;
      e = 32'(i + 1) << 16;
      chk("id_link", 32'(q_link[i]), 32'(7 - i));
      chk("id_dtau", q_dtau[i], e);
      chk("id_done", 32'(q_done[i]), 32'(i == 6));
      if (i > 0) chk("id_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 32'd3);
    end
    chk("id_err", 32'(err_out), 32'd0);

    // Rotation by 90 deg moves LX into LY; a later offset turns it into AZ torque.
    clear_q();
    set_in(3'd7, ONE, '0, '0, '0, '0, '0, '0, '0, ONE, '0, '0);
    send();
    set_in(3'd6, '0, ONE, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    send();
    set_in(3'd5, '0, ONE, ONE, '0, '0, '0, '0, '0, '0, '0, '0);
    send();
    set_in(3'd4, '0, ONE, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    send();
    valid_in = 1'b0;
    wait_pulses(4);
    if (q_dtau.size() >= 4) begin
      chk("rot_dtau7", q_dtau[0], 32'd0);
      chk("rot_dtau6", q_dtau[1], 32'd0);
      chk("rot_dtau5", q_dtau[2], 32'd0);
      chk("rot_dtau4", q_dtau[3], ONE);
    end
    do_reset();

    // Cross product: r=(1,0,0), LY=1 gives AZ=1 at the parent; plus 0.5 local.
    set_in(3'd7, '0, ONE, ONE, '0, '0, '0, '0, '0, '0, ONE, '0);
    send();
    set_in(3'd6, '0, ONE, '0, '0, '0, '0, '0, 32'h0000_8000, '0, '0, '0);
    send();
    valid_in = 1'b0;
    wait_pulses(2);
    if (q_dtau.size() >= 2) begin
      chk("x_dtau7", q_dtau[0], 32'd0);
      chk("x_dtau6", q_dtau[1], 32'h0001_8000);
    end
    do_reset();

    // Signed: c=0.5, LY=-3.0, rx=2.0 -> parent AZ=-3.0; plus 0.25 -> -2.75.
    set_in(3'd7, '0, 32'h0000_8000, 32'h0002_0000, '0, '0, '0, '0, '0, '0, 32'hFFFD_0000, '0);
    send();
    set_in(3'd6, '0, ONE, '0, '0, '0, '0, '0, 32'h0000_4000, '0, '0, '0);
    send();
    valid_in = 1'b0;
    wait_pulses(2);
    if (q_dtau.size() >= 2) chk("neg_dtau6", q_dtau[1], 32'hFFFD_4000);
    do_reset();

    // Order error in IDLE, then a chained error in S3, then normal progress.
    set_in(3'd5, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    valid_in = 1'b0;
    chk("err_set", 32'(err_out), 32'd1);
    chk("err_ready", 32'(ready_out), 32'd1);
    tick();
    tick();
    tick();
    tick();
    chk("err_nopulse", 32'(q_link.size()), 32'd0);
    set_in(3'd7, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    set_in(3'd3, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    valid_in = 1'b0;
    set_in(3'd6, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    valid_in = 1'b0;
    wait_pulses(2);
    tick();
    tick();
    tick();
    tick();
    chk("err_pulses", 32'(q_link.size()), 32'd2);
    if (q_dtau.size() >= 2) begin
      chk("err_link7", 32'(q_link[0]), 32'd7);
      chk("err_dtau7", q_dtau[0], ONE);
      chk("err_link6", 32'(q_link[1]), 32'd6);
      chk("err_dtau6", q_dtau[1], 32'h0002_0000);
    end
    chk("err_sticky", 32'(err_out), 32'd1);

    // Backpressure: valid_in held from reset; accepts only on edges 0 and 3.
    reset = 1'b1;
    set_in(3'd7, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    valid_in = 1'b1;
    tick();
    reset = 1'b0;
    clear_q();
    tick();
    chk("bp_s1_ready", 32'(ready_out), 32'd0);
    set_in(3'd6, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    tick();
    chk("bp_s2_ready", 32'(ready_out), 32'd0);
    tick();
    chk("bp_s3_ready", 32'(ready_out), 32'd1);
    tick();
    chk("bp_e3_ready", 32'(ready_out), 32'd0);
    chk("bp_e3_valid", 32'(dtau_valid_out), 32'd1);
    chk("bp_e3_link", 32'(link_out), 32'd7);
    valid_in = 1'b0;
    wait_pulses(2);
    if (q_dtau.size() >= 2) begin
      chk("bp_dtau6", q_dtau[1], 32'h0002_0000);
      chk("bp_spacing", 32'(q_cyc[1] - q_cyc[0]), 32'd3);
    end
    chk("bp_err", 32'(err_out), 32'd0);
    do_reset();

    // Reset during link 6 S2 aborts cleanly and leaves no stale accumulation.
    set_in(3'd7, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    set_in(3'd6, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    tick();
    valid_in = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    tick();
    reset = 1'b0;
    clear_q();
    tick();
    tick();
    tick();
    chk("mid_nopulse", 32'(q_link.size()), 32'd0);
    set_in(3'd7, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    set_in(3'd6, '0, ONE, '0, '0, '0, '0, '0, ONE, '0, '0, '0);
    send();
    valid_in = 1'b0;
    wait_pulses(2);
    if (q_dtau.size() >= 2) begin
      chk("mid_dtau7", q_dtau[0], ONE);
      chk("mid_dtau6", q_dtau[1], 32'h0002_0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
